// File: rtl/demux_reg_n_if.sv
// Handshake and output bus of the registered 1-to-N demultiplexer.
// The producer/consumer side uses the master modport; the demux itself uses slave.
interface demux_reg_n_if #(
  parameter int DATA_BITS   = 4,
  parameter int NUM_SALIDAS = 4
);
  localparam int SEL_BITS = (NUM_SALIDAS > 1) ? $clog2(NUM_SALIDAS) : 1;

  logic                             enb;
  logic                             valid_entrada;
  logic [DATA_BITS-1:0]             entrada_dmux;
  logic [SEL_BITS-1:0]              selector_dmux;
  logic                             listo_entrada;
  logic [NUM_SALIDAS*DATA_BITS-1:0] salida_dmux;
  logic [NUM_SALIDAS-1:0]           valid_salida;
  logic [NUM_SALIDAS-1:0]           pop_salida;
  logic                             error_sel;
  logic [7:0]                       cuenta_descartes;

  modport master (
    output enb, valid_entrada, entrada_dmux, selector_dmux, pop_salida,
    input  listo_entrada, salida_dmux, valid_salida, error_sel, cuenta_descartes
  );

  modport slave (
    input  enb, valid_entrada, entrada_dmux, selector_dmux, pop_salida,
    output listo_entrada, salida_dmux, valid_salida, error_sel, cuenta_descartes
  );
endinterface

// File: rtl/demux_reg_n.sv
// Registered 1-to-N demultiplexer: one holding slot per channel, valid/ready input,
// per-channel pop, and drop/count of words addressed past the last channel.
module demux_reg_n #(
  parameter int DATA_BITS   = 4,
  parameter int NUM_SALIDAS = 4
) (
  input  logic         clk,
  input  logic         reset,
  demux_reg_n_if.slave bus
);
  localparam int SEL_BITS = (NUM_SALIDAS > 1) ? $clog2(NUM_SALIDAS) : 1;

  logic [DATA_BITS-1:0]   slot_q [NUM_SALIDAS];
  logic [NUM_SALIDAS-1:0] valid_q;
  logic                   error_q;
  logic [7:0]             count_q;

  logic [SEL_BITS-1:0]    sel;
  logic                   sel_ok;
  logic                   ready;
  logic                   drop;
  logic [NUM_SALIDAS-1:0] write_en;
  logic [NUM_SALIDAS-1:0] pop_fire;

  assign sel = bus.selector_dmux;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sel_ok   = int'(sel) < NUM_SALIDAS;
    ready    = 1'b0;
    drop     = 1'b0;
    write_en = '0;
    pop_fire = bus.pop_salida & valid_q;
    if (bus.enb) begin
      // Out-of-range words are always taken so they can be dropped and counted.
      if (!sel_ok) ready = 1'b1;
      else         ready = !valid_q[sel] | bus.pop_salida[sel];
    end
    if (bus.valid_entrada && ready) begin
      if (sel_ok) write_en[sel] = 1'b1;
      else        drop          = 1'b1;
    end
  end

  // NOTE: the slot array is small and its contents are visible on salida_dmux, so it is reset
  // like any other register rather than left as uninitialised storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SALIDAS; i++) slot_q[i] <= '0;
      valid_q <= '0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge order-independent.
      for (int i = 0; i < NUM_SALIDAS; i++) begin
        // A write wins over a same-cycle pop, so a reloaded slot never drops valid.
        if (write_en[i]) begin
          slot_q[i]  <= bus.entrada_dmux;
          valid_q[i] <= 1'b1;
        end else if (pop_fire[i]) begin
          slot_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end
      end
      error_q <= drop;
      if (drop && count_q != 8'hFF) count_q <= count_q + 8'd1;
    end
  end

  // Popped slots are cleared to zero, so empty channels never show stale data.
  for (genvar g = 0; g < NUM_SALIDAS; g++) begin : g_out
    assign bus.salida_dmux[g*DATA_BITS +: DATA_BITS] = slot_q[g];
  end

  assign bus.listo_entrada    = ready;
  assign bus.valid_salida     = valid_q;
  assign bus.error_sel        = error_q;
  assign bus.cuenta_descartes = count_q;
endmodule

// File: tb/tb_demux_reg_n.sv
// Self-checking bench: a 4-channel and a 3-channel demux share one stimulus stream and are
// compared every cycle against a behavioural slot model.
module tb_demux_reg_n;
  logic clk;
  logic reset;

  demux_reg_n_if #(.DATA_BITS(4), .NUM_SALIDAS(4)) if4 ();
  demux_reg_n_if #(.DATA_BITS(4), .NUM_SALIDAS(3)) if3 ();

  demux_reg_n #(.DATA_BITS(4), .NUM_SALIDAS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  demux_reg_n #(.DATA_BITS(4), .NUM_SALIDAS(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: index 0 is the 4-channel instance, index 1 the 3-channel one.
  int  n_ch    [2] = '{4, 3};
  int  m_slot  [2][4];
  bit  m_valid [2][4];
  int  m_cnt   [2];
  bit  m_err   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_slot[k][i]  = 0;
        m_valid[k][i] = 1'b0;
      end
      m_cnt[k] = 0;
      m_err[k] = 1'b0;
    end
  endfunction

  function automatic logic exp_ready(int k, logic e, logic [1:0] s, logic [3:0] p);
    if (!e) return 1'b0;
    if (int'(s) >= n_ch[k]) return 1'b1;
    return !m_valid[k][s] || p[s];
  endfunction

  function automatic logic [31:0] exp_flat(int k);
    logic [31:0] f = '0;
    for (int i = 0; i < n_ch[k]; i++)
      if (m_valid[k][i]) f[i*4 +: 4] = 4'(m_slot[k][i]);
    return f;
  endfunction

  function automatic logic [31:0] exp_vmask(int k);
    logic [31:0] m = '0;
    for (int i = 0; i < n_ch[k]; i++) m[i] = m_valid[k][i];
    return m;
  endfunction

  function automatic void model_edge(int k, logic e, logic v, logic [1:0] s, logic [3:0] d,
                                     logic [3:0] p);
    logic acc = v && exp_ready(k, e, s, p);
    for (int i = 0; i < n_ch[k]; i++)
      if (p[i] && m_valid[k][i]) begin
        m_valid[k][i] = 1'b0;
        m_slot[k][i]  = 0;
      end
    if (acc && int'(s) < n_ch[k]) begin
      m_valid[k][s] = 1'b1;
      m_slot[k][s]  = int'(d);
    end
    m_err[k] = acc && int'(s) >= n_ch[k];
    if (m_err[k]) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
  endfunction

  task automatic check_state(input string tag);
    check({tag, " d4 valid"}, 32'(if4.valid_salida),     exp_vmask(0));
    check({tag, " d4 data"},  32'(if4.salida_dmux),      exp_flat(0));
    check({tag, " d4 err"},   32'(if4.error_sel),        32'(m_err[0]));
    check({tag, " d4 cnt"},   32'(if4.cuenta_descartes), 32'(m_cnt[0]));
    check({tag, " d3 valid"}, 32'(if3.valid_salida),     exp_vmask(1));
    check({tag, " d3 data"},  32'(if3.salida_dmux),      exp_flat(1));
    check({tag, " d3 err"},   32'(if3.error_sel),        32'(m_err[1]));
    check({tag, " d3 cnt"},   32'(if3.cuenta_descartes), 32'(m_cnt[1]));
  endtask

  // One clock cycle: drive at the falling edge, check ready, clock, check registered state.
  task automatic step(input string tag, input logic e, input logic v, input logic [1:0] s,
                      input logic [3:0] d, input logic [3:0] p);
    if4.enb = e; if4.valid_entrada = v; if4.selector_dmux = s; if4.entrada_dmux = d;
    if4.pop_salida = p;
    if3.enb = e; if3.valid_entrada = v; if3.selector_dmux = s; if3.entrada_dmux = d;
    if3.pop_salida = p[2:0];
    #1;
    check({tag, " d4 ready"}, 32'(if4.listo_entrada), 32'(exp_ready(0, e, s, p)));
    check({tag, " d3 ready"}, 32'(if3.listo_entrada), 32'(exp_ready(1, e, s, p)));
    @(posedge clk);
    model_edge(0, e, v, s, d, p);
    model_edge(1, e, v, s, d, p);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1;
    if4.enb = 1'b0; if4.valid_entrada = 1'b0; if4.selector_dmux = '0; if4.entrada_dmux = '0;
    if4.pop_salida = '0;
    if3.enb = 1'b0; if3.valid_entrada = 1'b0; if3.selector_dmux = '0; if3.entrada_dmux = '0;
    if3.pop_salida = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    reset = 1'b0;

    // 1: single word to channel 2, then ready for sel=2 depends on pop[2].
    step("t1 load", 1, 1, 2'd2, 4'hA, 4'b0000);
    check("t1 valid const", 32'(if4.valid_salida), 32'h4);
    check("t1 data const",  32'(if4.salida_dmux),  32'h0A00);
    step("t1 blocked", 1, 0, 2'd2, 4'h0, 4'b0000);
    step("t1 popready", 1, 0, 2'd2, 4'h0, 4'b0100);

    // 2: full slot back-pressure, then simultaneous pop+write keeps valid high.
    step("t2 fill", 1, 1, 2'd1, 4'h3, 4'b0000);
    step("t2 stall", 1, 1, 2'd1, 4'h5, 4'b0000);
    check("t2 keep", 32'(if4.salida_dmux[7:4]), 32'h3);
    step("t2 swap", 1, 1, 2'd1, 4'h5, 4'b0010);
    check("t2 new", 32'(if4.salida_dmux[7:4]), 32'h5);
    check("t2 vhold", 32'(if4.valid_salida[1]), 32'h1);
    step("t2 drain", 1, 0, 2'd0, 4'h0, 4'b0010);

    // 4: fill every channel, pop all at once, then pop again on empty slots.
    for (int i = 0; i < 4; i++) step("t4 fill", 1, 1, 2'(i), 4'(i + 1), 4'b0000);
    step("t4 popall", 1, 0, 2'd0, 4'h0, 4'b1111);
    check("t4 empty", 32'(if4.salida_dmux), 32'h0);
    step("t4 popempty", 1, 0, 2'd0, 4'h0, 4'b1111);

    // 5: disabled block accepts nothing but still drains.
    step("t5 fill", 1, 1, 2'd0, 4'h7, 4'b0000);
    step("t5 off", 0, 1, 2'd1, 4'h9, 4'b0000);
    step("t5 offpop", 0, 1, 2'd1, 4'h9, 4'b0001);
    step("t5 offsel3", 0, 1, 2'd3, 4'h9, 4'b0000);

    // 3: sustained out-of-range traffic saturates the 3-channel drop counter.
    for (int i = 0; i < 300; i++) step("t3 drop", 1, 1, 2'd3, 4'($urandom), 4'b0000);
    check("t3 sat", 32'(if3.cuenta_descartes), 32'd255);
    check("t3 noslot", 32'(if3.valid_salida), 32'h0);
    step("t3 idle", 1, 0, 2'd3, 4'h0, 4'b0000);

    // 6: asynchronous reset between edges with three slots full.
    for (int i = 0; i < 3; i++) step("t6 fill", 1, 1, 2'(i), 4'(4'hC + i), 4'b0000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_state("t6 async");
    @(negedge clk);
    check_state("t6 held");
    reset = 1'b0;
    step("t6 idle", 1, 0, 2'd0, 4'h0, 4'b0000);
    step("t6 idle2", 0, 1, 2'd1, 4'h2, 4'b0000);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
           4'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/demux_reg_n.md
Name: demux_reg_n

Overview:
Registered, parametrised 1-to-N demultiplexer with a valid/ready handshake on the input and a one-entry holding register per output channel.
- Each accepted word is steered by selector_dmux into its channel's slot.
- The word is held there until the consumer pops it.
- Words addressed to non-existent channels are dropped, flagged and counted.
- Sits between the serial front-end and the per-lane consumers, replacing the fixed 4-way combinational demux where back-pressure is needed.

Parameters:
DATA_BITS, 4, width of each data word.
NUM_SALIDAS, 4, number of output channels (2..16).
SEL_BITS, $clog2(NUM_SALIDAS) (minimum 1), selector width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
enb  input  1  block enable; gates input acceptance only.
valid_entrada  input  1  input word valid.
entrada_dmux  input  DATA_BITS  input word.
selector_dmux  input  SEL_BITS  destination channel index.
listo_entrada  output  1  input ready (combinational).
salida_dmux  output  NUM_SALIDAS*DATA_BITS  flat bus; channel i at [i*DATA_BITS +: DATA_BITS].
valid_salida  output  NUM_SALIDAS  per-channel slot occupied.
pop_salida  input  NUM_SALIDAS  per-channel consumer read strobe.
error_sel  output  1  one-cycle pulse: a word with selector >= NUM_SALIDAS was dropped.
cuenta_descartes  output  8  saturating count of dropped words.

Behaviour:
- Reset (async, active-high): immediately clears all of the following; holds while reset=1; normal operation on first clk edge after deassertion. Applies equally mid-transfer: pending slots are discarded.
  - all slots, valid_salida = 0, salida_dmux = 0
  - error_sel = 0, cuenta_descartes = 0
- Selector validity: sel_ok = (selector_dmux < NUM_SALIDAS).
- listo_entrada is combinational:
  - If enb=0: listo_entrada=0.
  - If enb=1 and !sel_ok: listo_entrada=1 (the word is accepted so it can be dropped).
  - If enb=1 and sel_ok: listo_entrada = !valid_salida[s] | pop_salida[s], where s = selector_dmux.
- Transfer on a rising edge with valid_entrada & listo_entrada.
  - sel_ok: slot s <= entrada_dmux; valid_salida[s] <= 1. Latency 1 cycle: data visible on the cycle after acceptance.
  - !sel_ok: no slot changes; error_sel = 1 for exactly the next cycle; cuenta_descartes +1, saturating at 255.
- Pop: pop_salida[i] & valid_salida[i] on an edge empties slot i:
  - valid_salida[i] <= 0
  - channel i data <= 0
  - A pop on an empty slot is ignored; no error.
- Simultaneous pop and write to the same channel: the slot is reloaded with the new word; valid_salida[i] stays 1 and never glitches low. This gives full throughput of 1 word/cycle per channel.
- Simultaneous write to channel s and pops on other channels are independent; any number of pops may occur in the same cycle.
- Empty channels always drive 0 on their data field (no stale data).
- enb=0 with full slots: pops still drain; no new words enter; the counter holds.
- error_sel is registered; it is 0 in any cycle not directly following a drop.
- No combinational path from entrada_dmux to salida_dmux.

Test Plan:
1. Reset, then enb=1, valid=1, sel=2, data=4'hA for one cycle -> next cycle valid_salida=4'b0100, channel 2 field = A, all other fields 0, listo_entrada=1 for sel=2 only if pop_salida[2]=1.
2. Fill channel 1 with 4'h3, no pop; present 4'h5 to sel=1 -> listo_entrada=0 and the slot keeps 3. Assert pop_salida[1] in the same cycle -> 5 accepted; valid_salida[1] stays 1 continuously; channel 1 field reads 5 next cycle.
3. NUM_SALIDAS=3, sel=3, valid=1 for 300 consecutive cycles -> listo_entrada=1 each cycle; error_sel high each following cycle; cuenta_descartes saturates at 255; valid_salida stays 0.
4. Load all 4 channels, then pop_salida=4'b1111 in one cycle -> valid_salida=0 and salida_dmux=0 next cycle. A subsequent pop on empty channels produces no change.
5. enb=0 with valid=1 -> listo_entrada=0, nothing stored. A pending full slot still pops normally.
6. Assert reset asynchronously between clock edges with 3 slots full -> valid_salida, salida_dmux and cuenta_descartes are 0 before the next edge, and remain 0 until the first post-reset transfer.
